per2axi_req_channel: RTL and testbench
======================================

Name: per2axi_req_channel

Overview:
Request stage of the peripheral-to-AXI bridge. Accepts single-beat 32-bit peripheral requests and converts each one into AXI4 transactions. A write becomes one AW plus one W beat; a read becomes one AR. The AW output feeds the AW buffer and the W output feeds the write-data buffer directly downstream. Each accepted request is also announced to the response channel.

Parameters:
PER_ADDR_WIDTH, 32, peripheral address width
PER_ID_WIDTH, 5, peripheral request ID width
AXI_ADDR_WIDTH, 32, AXI address width (must be at least PER_ADDR_WIDTH)
AXI_DATA_WIDTH, 64, AXI data width (fixed at 64; do not override)
AXI_USER_WIDTH, 6, AXI user width
AXI_ID_WIDTH, 3, AXI ID width (must be at least PER_ID_WIDTH is not required; ID is truncated or zero-extended)
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width (derived; do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
per_slave_req_i  in  1  request valid
per_slave_add_i  in  PER_ADDR_WIDTH  byte address
per_slave_we_i  in  1  0 = write, 1 = read
per_slave_wdata_i  in  32  write data
per_slave_be_i  in  4  byte enables
per_slave_id_i  in  PER_ID_WIDTH  request ID
per_slave_gnt_o  out  1  grant
axi_master_aw_valid_o/ready_i  out/in  1  AW handshake
axi_master_aw_addr_o  out  AXI_ADDR_WIDTH  write address
axi_master_aw_len_o/size_o/burst_o  out  8/3/2  burst attributes
axi_master_aw_id_o  out  AXI_ID_WIDTH  write ID
axi_master_aw_user_o  out  AXI_USER_WIDTH  write user
axi_master_w_valid_o/ready_i  out/in  1  W handshake
axi_master_w_data_o  out  AXI_DATA_WIDTH  write data
axi_master_w_strb_o  out  AXI_STRB_WIDTH  write strobes
axi_master_w_user_o  out  AXI_USER_WIDTH  write-data user
axi_master_w_last_o  out  1  last beat
axi_master_ar_* (valid/ready, addr, len, size, burst, id, user)  same widths as AW  read address channel
trans_req_o  out  1  one-cycle pulse on each accepted request
trans_we_o  out  1  we of the accepted request
trans_id_o  out  PER_ID_WIDTH  ID of the accepted request
trans_add_o  out  PER_ADDR_WIDTH  address of the accepted request (response channel uses bit 2 for lane select)

Behaviour:
- Reset values: all valid outputs, gnt and trans_req are 0; all registered payload outputs are 0.
- FSM states: IDLE, WR_BOTH, WR_AW, WR_W, RD.
- IDLE:
  - gnt_o = req_i, combinational.
  - On req & gnt, all payload is registered and trans_* is pulsed for that cycle.
  - Next state is WR_BOTH when we_i = 0, RD when we_i = 1.
- WR_BOTH: aw_valid = 1 and w_valid = 1.
  - Both handshakes in the same cycle -> IDLE.
  - AW handshake only -> WR_W.
  - W handshake only -> WR_AW.
- WR_AW: aw_valid = 1 only; AW handshake -> IDLE.
- WR_W: w_valid = 1 only; W handshake -> IDLE.
- RD: ar_valid = 1; AR handshake -> IDLE.
- gnt_o = 0 in every state other than IDLE.
- Latency: first valid appears one cycle after the grant.
- Valid outputs never depend on the corresponding ready. Payload is held stable while valid is high.
- Address and attributes: addr = add zero-extended to AXI_ADDR_WIDTH; len = 0; size = 3'b010; burst = 2'b01 (INCR); user = 0.
- ID: per_slave_id_i zero-extended, or truncated to its LSBs, to AXI_ID_WIDTH.
- Write data: wdata is replicated into both 32-bit halves. w_strb = {4'b0, be} when add[2] = 0, and {be, 4'b0} when add[2] = 1. w_last = 1.
- be = 0 on a write is still issued, with all-zero strobes.
- Asynchronous reset at any point returns the FSM to IDLE and drops all valids immediately; any partially issued transaction is abandoned.

Optional Feature:
PER2AXI_BACK2BACK_EN
- Defined: gnt_o is also asserted in the cycle in which the last pending handshake of the current transaction completes. A new request is captured in that cycle and the FSM moves directly to WR_BOTH or RD, with no IDLE cycle. Sustained throughput is one transaction per cycle when ready is held high.
- Undefined: the FSM always spends at least one cycle in IDLE between transactions, limiting throughput to one transaction every 2 cycles.

Test Plan:
- Write: add = 0x1000_0004, wdata = 0xDEADBEEF, be = 0xF, id = 3, all ready = 1 -> gnt in cycle 0. In cycle 1: aw_addr = 0x1000_0004, aw_id = 3, w_data = 0xDEADBEEF_DEADBEEF, w_strb = 0xF0, w_last = 1. FSM back in IDLE in cycle 2.
- Write: add = 0x0000_0000, be = 0x3, aw_ready = 1, w_ready held 0 for 3 cycles -> AW completes in cycle 1; w_valid stays 1 with stable data (strb = 0x03) until the W handshake in cycle 4; gnt = 0 throughout.
- Write with w_ready = 1 and aw_ready = 0 for 2 cycles -> FSM goes through WR_AW; aw_addr stays stable; new requests are not granted until the AW handshake.
- Read: add = 0x2000_0008, id = 7 -> ar_valid in cycle 1 with ar_addr = 0x2000_0008, ar_size = 2; trans_req pulse in cycle 0 with trans_we = 1 and trans_id = 7; aw_valid and w_valid stay 0.
- 4 back-to-back writes, all ready = 1 -> transactions complete in 4 cycles with PER2AXI_BACK2BACK_EN defined, and in 8 cycles without it.
- rst_ni asserted while in WR_W -> w_valid = 0 immediately; after reset release the next request is granted from IDLE.

Source files
------------

// File: rtl/per2axi_req_channel.sv
// Request stage of the peripheral-to-AXI bridge: turns single-beat peripheral requests into AW+W or AR.
// Optional macro PER2AXI_BACK2BACK_EN lets a new request be granted in the cycle the current one completes.
module per2axi_req_channel #(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int PER_ID_WIDTH   = 5,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
    output logic                      per_slave_gnt_o,
    output logic                      axi_master_aw_valid_o,
    input  logic                      axi_master_aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] axi_master_aw_addr_o,
    output logic [7:0]                axi_master_aw_len_o,
    output logic [2:0]                axi_master_aw_size_o,
    output logic [1:0]                axi_master_aw_burst_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_master_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_master_aw_user_o,
    output logic                      axi_master_w_valid_o,
    input  logic                      axi_master_w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] axi_master_w_data_o,
    output logic [AXI_STRB_WIDTH-1:0] axi_master_w_strb_o,
    output logic [AXI_USER_WIDTH-1:0] axi_master_w_user_o,
    output logic                      axi_master_w_last_o,
    output logic                      axi_master_ar_valid_o,
    input  logic                      axi_master_ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] axi_master_ar_addr_o,
    output logic [7:0]                axi_master_ar_len_o,
    output logic [2:0]                axi_master_ar_size_o,
    output logic [1:0]                axi_master_ar_burst_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_master_ar_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_master_ar_user_o,
    output logic                      trans_req_o,
    output logic                      trans_we_o,
    output logic [PER_ID_WIDTH-1:0]   trans_id_o,
    output logic [PER_ADDR_WIDTH-1:0] trans_add_o
);

`ifdef PER2AXI_BACK2BACK_EN
    localparam logic B2B_EN = 1'b1;
`else
    localparam logic B2B_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WR_BOTH, WR_AW, WR_W, RD} state_e;

    state_e                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_STRB_WIDTH-1:0] strb_q;
    logic                      aw_valid_q;
    logic                      w_valid_q;
    logic                      ar_valid_q;

    logic aw_hs_s;
    logic w_hs_s;
    logic ar_hs_s;
    logic done_s;
    logic gnt_s;
    logic accept_s;

    // The 32-bit word sits in the upper half of the 64-bit beat when address bit 2 is set.
    function automatic logic [AXI_STRB_WIDTH-1:0] lane_strb(input logic hi, input logic [3:0] be);
        if (hi) begin
            lane_strb = {be, 4'b0000};
        end else begin
            lane_strb = {4'b0000, be};
        end
    endfunction

    assign aw_hs_s  = aw_valid_q & axi_master_aw_ready_i;
    assign w_hs_s   = w_valid_q & axi_master_w_ready_i;
    assign ar_hs_s  = ar_valid_q & axi_master_ar_ready_i;
    assign accept_s = per_slave_req_i & gnt_s;

    // Detects the cycle in which the last outstanding handshake of the current transaction completes.
    always_comb begin
        done_s = 1'b0;
        case (state_q)
            WR_BOTH: done_s = aw_hs_s & w_hs_s;
            WR_AW:   done_s = aw_hs_s;
            WR_W:    done_s = w_hs_s;
            RD:      done_s = ar_hs_s;
            default: done_s = 1'b0;
        endcase
    end

    // Grant generation: always in IDLE, optionally also on completion.
    always_comb begin
        if (state_q == IDLE) begin
            gnt_s = per_slave_req_i;
        end else if (B2B_EN) begin
            gnt_s = per_slave_req_i & done_s;
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Transaction FSM with registered valids and payload; payload only changes on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= {AXI_ADDR_WIDTH{1'b0}};
            id_q       <= {AXI_ID_WIDTH{1'b0}};
            wdata_q    <= {AXI_DATA_WIDTH{1'b0}};
            strb_q     <= {AXI_STRB_WIDTH{1'b0}};
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
        end else if (accept_s) begin
            addr_q  <= AXI_ADDR_WIDTH'(per_slave_add_i);
            id_q    <= AXI_ID_WIDTH'(per_slave_id_i);
            wdata_q <= {2{per_slave_wdata_i}};
            strb_q  <= lane_strb(per_slave_add_i[2], per_slave_be_i);
            if (per_slave_we_i) begin
                state_q    <= RD;
                aw_valid_q <= 1'b0;
                w_valid_q  <= 1'b0;
                ar_valid_q <= 1'b1;
            end else begin
                state_q    <= WR_BOTH;
                aw_valid_q <= 1'b1;
                w_valid_q  <= 1'b1;
                ar_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                WR_BOTH: begin
                    if (aw_hs_s && w_hs_s) begin
                        state_q    <= IDLE;
                        aw_valid_q <= 1'b0;
                        w_valid_q  <= 1'b0;
                    end else if (aw_hs_s) begin
                        state_q    <= WR_W;
                        aw_valid_q <= 1'b0;
                    end else if (w_hs_s) begin
                        state_q   <= WR_AW;
                        w_valid_q <= 1'b0;
                    end
                end
                WR_AW: begin
                    if (aw_hs_s) begin
                        state_q    <= IDLE;
                        aw_valid_q <= 1'b0;
                    end
                end
                WR_W: begin
                    if (w_hs_s) begin
                        state_q   <= IDLE;
                        w_valid_q <= 1'b0;
                    end
                end
                RD: begin
                    if (ar_hs_s) begin
                        state_q    <= IDLE;
                        ar_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b0;
                    ar_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign per_slave_gnt_o       = gnt_s;
    assign trans_req_o           = accept_s;
    assign trans_we_o            = per_slave_we_i;
    assign trans_id_o            = per_slave_id_i;
    assign trans_add_o           = per_slave_add_i;

    assign axi_master_aw_valid_o = aw_valid_q;
    assign axi_master_aw_addr_o  = addr_q;
    assign axi_master_aw_len_o   = 8'd0;
    assign axi_master_aw_size_o  = 3'b010;
    assign axi_master_aw_burst_o = 2'b01;
    assign axi_master_aw_id_o    = id_q;
    assign axi_master_aw_user_o  = {AXI_USER_WIDTH{1'b0}};

    assign axi_master_w_valid_o  = w_valid_q;
    assign axi_master_w_data_o   = wdata_q;
    assign axi_master_w_strb_o   = strb_q;
    assign axi_master_w_user_o   = {AXI_USER_WIDTH{1'b0}};
    assign axi_master_w_last_o   = 1'b1;

    assign axi_master_ar_valid_o = ar_valid_q;
    assign axi_master_ar_addr_o  = addr_q;
    assign axi_master_ar_len_o   = 8'd0;
    assign axi_master_ar_size_o  = 3'b010;
    assign axi_master_ar_burst_o = 2'b01;
    assign axi_master_ar_id_o    = id_q;
    assign axi_master_ar_user_o  = {AXI_USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_per2axi_req_channel.sv
// Scoreboard bench for per2axi_req_channel: a pending-beat model predicts grants, valids and payloads.
module tb_per2axi_req_channel;

`ifdef PER2AXI_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0;
    logic [31:0] add = 32'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  be = 4'd0;
    logic [4:0]  id = 5'd0;
    logic        gnt;
    logic        aw_valid, aw_ready = 1'b1;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [2:0]  aw_id;
    logic [5:0]  aw_user;
    logic        w_valid, w_ready = 1'b1;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [5:0]  w_user;
    logic        w_last;
    logic        ar_valid, ar_ready = 1'b1;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [2:0]  ar_id;
    logic [5:0]  ar_user;
    logic        trans_req, trans_we;
    logic [4:0]  trans_id;
    logic [31:0] trans_add;

    per2axi_req_channel dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_i(we),
        .per_slave_wdata_i(wdata), .per_slave_be_i(be), .per_slave_id_i(id),
        .per_slave_gnt_o(gnt),
        .axi_master_aw_valid_o(aw_valid), .axi_master_aw_ready_i(aw_ready),
        .axi_master_aw_addr_o(aw_addr), .axi_master_aw_len_o(aw_len),
        .axi_master_aw_size_o(aw_size), .axi_master_aw_burst_o(aw_burst),
        .axi_master_aw_id_o(aw_id), .axi_master_aw_user_o(aw_user),
        .axi_master_w_valid_o(w_valid), .axi_master_w_ready_i(w_ready),
        .axi_master_w_data_o(w_data), .axi_master_w_strb_o(w_strb),
        .axi_master_w_user_o(w_user), .axi_master_w_last_o(w_last),
        .axi_master_ar_valid_o(ar_valid), .axi_master_ar_ready_i(ar_ready),
        .axi_master_ar_addr_o(ar_addr), .axi_master_ar_len_o(ar_len),
        .axi_master_ar_size_o(ar_size), .axi_master_ar_burst_o(ar_burst),
        .axi_master_ar_id_o(ar_id), .axi_master_ar_user_o(ar_user),
        .trans_req_o(trans_req), .trans_we_o(trans_we),
        .trans_id_o(trans_id), .trans_add_o(trans_add)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
        logic [3:0]  be;
        logic [4:0]  id;
    } req_t;

    req_t         req_q[$];
    logic [127:0] aw_q[$];
    logic [127:0] w_q[$];
    logic [127:0] ar_q[$];
    int           acc_cyc[$];
    bit           aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    bit           rdy_rand = 1'b0;
    int           cyc = 0;
    int           total = 0;
    int           passed = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        total++;
        $display("FAIL %s at t=%0t", nm, $time);
    endtask

    // Monitor + reference model: each accepted request creates pending beats that retire on ready.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_ni) begin
                aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
                aw_q.delete(); w_q.delete(); ar_q.delete();
            end else begin
                bit   idle, done, exp_gnt;
                req_t r;
                idle    = !aw_pend && !w_pend && !ar_pend;
                done    = (!aw_pend || aw_ready) && (!w_pend || w_ready) && (!ar_pend || ar_ready);
                exp_gnt = req && (idle || (B2B && done));
                chk("gnt", gnt, exp_gnt);
                chk("aw_valid", aw_valid, aw_pend);
                chk("w_valid", w_valid, w_pend);
                chk("ar_valid", ar_valid, ar_pend);
                if (aw_pend) begin
                    if (aw_q.size() == 0) fail_now("aw_queue_empty");
                    else chk("aw_payload", {aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_user}, aw_q[0]);
                    if (aw_ready) begin
                        aw_pend = 1'b0;
                        if (aw_q.size() != 0) void'(aw_q.pop_front());
                    end
                end
                if (w_pend) begin
                    if (w_q.size() == 0) fail_now("w_queue_empty");
                    else chk("w_payload", {w_data, w_strb, w_last, w_user}, w_q[0]);
                    if (w_ready) begin
                        w_pend = 1'b0;
                        if (w_q.size() != 0) void'(w_q.pop_front());
                    end
                end
                if (ar_pend) begin
                    if (ar_q.size() == 0) fail_now("ar_queue_empty");
                    else chk("ar_payload", {ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_user}, ar_q[0]);
                    if (ar_ready) begin
                        ar_pend = 1'b0;
                        if (ar_q.size() != 0) void'(ar_q.pop_front());
                    end
                end
                chk("trans_req", trans_req, exp_gnt);
                if (exp_gnt) begin
                    if (req_q.size() == 0) begin
                        fail_now("req_queue_empty");
                    end else begin
                        logic [2:0]  eid;
                        logic [63:0] edata;
                        logic [7:0]  estrb;
                        r     = req_q.pop_front();
                        eid   = 3'(r.id % 8);
                        edata = {32'd0, r.d} * 64'h0000_0001_0000_0001;
                        estrb = r.a[2] ? 8'(r.be * 16) : {4'd0, r.be};
                        chk("trans_fields", {trans_we, trans_id, trans_add}, {r.we, r.id, r.a});
                        acc_cyc.push_back(cyc);
                        if (r.we) begin
                            ar_q.push_back({r.a, eid, 8'd0, 3'd2, 2'd1, 6'd0});
                            ar_pend = 1'b1;
                        end else begin
                            aw_q.push_back({r.a, eid, 8'd0, 3'd2, 2'd1, 6'd0});
                            w_q.push_back({edata, estrb, 1'b1, 6'd0});
                            aw_pend = 1'b1;
                            w_pend  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Random backpressure on the three ready inputs while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) begin
                aw_ready = ($urandom_range(0, 9) < 7);
                w_ready  = ($urandom_range(0, 9) < 7);
                ar_ready = ($urandom_range(0, 9) < 7);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] b, input logic [4:0] i);
        bit ok;
        req_t r;
        r.a = a; r.we = w; r.d = d; r.be = b; r.id = i;
        req_q.push_back(r);
        add = a; we = w; wdata = d; be = b; id = i; req = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (gnt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("grant_timeout");
            void'(req_q.pop_back());
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #1;
            if (!aw_pend && !w_pend && !ar_pend && aw_q.size() == 0 && w_q.size() == 0 && ar_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valids", {aw_valid, w_valid, ar_valid}, 3'b000);
        chk("rst_gnt_trans", {gnt, trans_req}, 2'b00);
        chk("rst_payload", {aw_addr, aw_id, w_data, w_strb}, 107'd0);
        @(posedge clk);
        #3;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Aligned-upper-lane write, everything ready.
        issue(32'h1000_0004, 1'b0, 32'hDEAD_BEEF, 4'hF, 5'd3);
        wait_idle();

        // W back-pressured for three cycles.
        aw_ready = 1'b1; w_ready = 1'b0;
        issue(32'h0000_0000, 1'b0, 32'h1234_5678, 4'h3, 5'd9);
        repeat (3) @(posedge clk);
        #1;
        w_ready = 1'b1;
        wait_idle();

        // AW back-pressured; a second request must wait for the AW handshake.
        aw_ready = 1'b0; w_ready = 1'b1;
        issue(32'h0000_0104, 1'b0, 32'hCAFE_F00D, 4'h5, 5'd30);
        fork
            issue(32'h0000_0200, 1'b1, 32'd0, 4'hF, 5'd1);
            begin
                repeat (2) @(posedge clk);
                #2;
                aw_ready = 1'b1;
            end
        join
        wait_idle();

        // Read and zero-strobe write.
        issue(32'h2000_0008, 1'b1, 32'd0, 4'hF, 5'd7);
        issue(32'h0000_0010, 1'b0, 32'hA5A5_5A5A, 4'h0, 5'd12);
        wait_idle();

        // Back-to-back throughput with all ready high.
        acc_cyc.delete();
        for (int k = 0; k < 4; k++) issue(32'h0000_1000 + 32'(k * 4), 1'b0, 32'(k), 4'hF, 5'(k));
        wait_idle();
        if (acc_cyc.size() != 4) fail_now("b2b_count");
        else chk("b2b_span", 32'(acc_cyc[3] - acc_cyc[0]), B2B ? 32'd3 : 32'd6);

        // Reset while stuck in the W-only phase.
        aw_ready = 1'b1; w_ready = 1'b0;
        issue(32'h0000_0044, 1'b0, 32'h0BAD_F00D, 4'h9, 5'd2);
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valids", {aw_valid, w_valid, ar_valid}, 3'b000);
        repeat (2) @(posedge clk);
        #3;
        rst_ni = 1'b1;
        w_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h0000_0048, 1'b0, 32'h1111_2222, 4'hC, 5'd4);
        wait_idle();

        // Randomized traffic under random backpressure.
        rdy_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            issue($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #2;
        aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
        wait_idle();
        chk("req_q_empty", 32'(req_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
